// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage, carry registered between stages.
// Define ADD_PIPE_FLAGS_EN to build the ovf/zero flag logic; otherwise both flag ports are tied to 0.
module add_pipe #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic             adv;

    // Register k holds the operands, the partial sum with slices 0..k filled and the carry out of slice k.
    logic             vld_q [STAGES];
    logic             vld_d [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_q   [STAGES];
    logic             c_d   [STAGES];

    // Inputs seen by each stage: the ports for stage 0, the previous register otherwise.
    logic             src_v [STAGES];
    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic [CHUNK:0]   part  [STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        src_v[0] = in_valid;
        src_a[0] = a;
        src_b[0] = sub ? ~b : b;
        src_c[0] = sub ? !cin : cin;
        src_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = vld_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_c[k] = c_q[k-1];
            src_s[k] = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part[k]  = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                     + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                     + (CHUNK+1)'(src_c[k]);
            vld_d[k] = src_v[k];
            a_d[k]   = src_a[k];
            b_d[k]   = src_b[k];
            c_d[k]   = part[k][CHUNK];
            s_d[k]   = src_s[k];
            s_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
            end
        end
    end

    assign out_valid = vld_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];

`ifdef ADD_PIPE_FLAGS_EN
    logic ovf_d, ovf_q, zero_d, zero_q;

    // Flags are formed from the fully assembled sum as it enters the output register.
    always_comb begin
        ovf_d  = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
                 (s_d[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
        zero_d = (s_d[LAST] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif
endmodule
